sio_rx_buffer: RTL

//  Serial receive front-end for the CPU serial port at I/O 0x84-0x85.

---
 rtl/sio_rx_buffer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sio_rx_buffer.sv
// Serial receive front-end: oversampled 8N1 deserialiser feeding a small
// first-word-fall-through FIFO with a valid/ready read port and sticky error flags.
module sio_rx_buffer #(
    parameter int OVS        = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rxd_i,
    input  logic                  tick16_i,
    output logic [7:0]            rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DEPTH_LOG2:0]   fifo_count_o,
    output logic                  overrun_o,
    output logic                  frame_err_o,
    input  logic                  err_clr_i,
    output logic [1:0]            state_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(OVS);
    localparam logic [TW-1:0]       T_MID    = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0]       T_END    = TW'(OVS - 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Read port handshake: a byte leaves the FIFO on any clk edge where
    // rd_valid_o & rd_ready_i; rd_data_o is stable while rd_valid_o is high
    // and unpopped, and rd_ready_i has no effect while rd_valid_o is low.

    logic                  rxd_meta_q, rxd_s_q;
    state_t                state_q, state_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shreg_q, shreg_d;
    logic                  push_req, ferr_set;
    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic [7:0]            mem_q [DEPTH];
    logic                  full, pop, do_push, ovr_set;
    logic                  overrun_q, overrun_d, frame_err_q, frame_err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_i;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
        if (tick16_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s_q) begin
                        state_d = S_START;
                        tcnt_d  = '0;
                    end
                end
                S_START: begin
                    if (tcnt_q == T_MID) begin
                        if (rxd_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            tcnt_d  = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tcnt_q == T_END) begin
                        shreg_d = {rxd_s_q, shreg_q[7:1]};
                        tcnt_d  = '0;
                        if (bit_q == 3'd7) state_d = S_STOP;
                        else               bit_d   = bit_q + 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                default: begin
                    // Stop sample lands mid-bit, so IDLE can see the next start edge.
                    if (tcnt_q == T_END) begin
                        if (rxd_s_q) push_req = 1'b1;
                        else         ferr_set = 1'b1;
                        state_d = S_IDLE;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign count      = wr_ptr_q - rd_ptr_q;
    assign full       = (count == FULL_CNT);
    assign rd_valid_o = (count != '0);
    assign pop        = rd_valid_o & rd_ready_i;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign do_push    = push_req & (~full | pop);
    assign ovr_set    = push_req & full & ~pop;

    assign wr_ptr_d    = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, do_push};
    assign rd_ptr_d    = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop};
    assign overrun_d   = (overrun_q & ~err_clr_i) | ovr_set;
    assign frame_err_d = (frame_err_q & ~err_clr_i) | ferr_set;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= shreg_q;
    end

    assign rd_data_o    = rd_valid_o ? mem_q[rd_ptr_q[DEPTH_LOG2-1:0]] : 8'h00;
    assign fifo_count_o = count;
    assign overrun_o    = overrun_q;
    assign frame_err_o  = frame_err_q;
    assign state_o      = state_q;

endmodule
